// File: rtl/playfield_lock_clear.sv
// Falling-block playfield: locks four-cell pieces, clears full rows bottom-up,
// keeps score and a sticky game-over flag.
module playfield_lock_clear #(
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int CW         = 3,
  parameter int SPAWN_ROWS = 3,
  localparam int XW        = $clog2(COLS),
  localparam int YW        = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lock_valid,
  output logic          lock_ready,
  input  logic [4*XW-1:0] lock_x,
  input  logic [4*YW-1:0] lock_y,
  input  logic [CW-1:0] lock_color,
  input  logic [4*XW-1:0] q_x,
  input  logic [4*YW-1:0] q_y,
  output logic          q_hit,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic          rd_occ,
  output logic [CW-1:0] rd_color,
  output logic          clear_done,
  output logic [2:0]    lines_last,
  output logic [15:0]   score,
  output logic          game_over
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SCAN, S_SHIFT, S_DONE} state_t;

  state_t              state_reg;
  logic [COLS-1:0]     occ_reg [ROWS];
  logic [CW-1:0]       col_reg [ROWS][COLS];
  logic [4*XW-1:0]     lx_reg;
  logic [4*YW-1:0]     ly_reg;
  logic [CW-1:0]       lc_reg;
  logic [YW-1:0]       r_reg;
  logic [2:0]          cnt_reg;
  logic [15:0]         score_reg;
  logic [2:0]          lines_last_reg;
  logic                clear_done_reg;
  logic                game_over_reg;

  logic [XW-1:0]       wr_x [4];
  logic [YW-1:0]       wr_y [4];
  logic                wr_en [4];
  logic [3:0]          q_hits;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cell
      logic [XW-1:0] qx;
      logic [YW-1:0] qy;
      assign wr_x[gi]   = lx_reg[gi*XW +: XW];
      assign wr_y[gi]   = ly_reg[gi*YW +: YW];
      assign wr_en[gi]  = (32'(wr_x[gi]) < COLS) && (32'(wr_y[gi]) < ROWS);
      assign qx         = q_x[gi*XW +: XW];
      assign qy         = q_y[gi*YW +: YW];
      assign q_hits[gi] = (32'(qx) >= COLS) || (32'(qy) >= ROWS) || occ_reg[qy][qx];
    end
  endgenerate

  logic rd_in;
  assign rd_in    = (32'(rd_x) < COLS) && (32'(rd_y) < ROWS);
  assign rd_occ   = rd_in && occ_reg[rd_y][rd_x];
  assign rd_color = rd_in ? col_reg[rd_y][rd_x] : '0;
  assign q_hit    = |q_hits;

  logic spawn_occ;
  always_comb begin
    spawn_occ = 1'b0;
    for (int i = 0; i < SPAWN_ROWS; i++) spawn_occ = spawn_occ | (|occ_reg[i]);
  end

  logic          row_full;
  logic          above_full;
  logic [YW-1:0] r_m1;
  assign row_full   = &occ_reg[r_reg];
  assign r_m1       = r_reg - YW'(1);
  assign above_full = (r_reg != '0) && (&occ_reg[r_m1]);

  logic [3:0]  inc;
  logic [16:0] score_sum;
  always_comb begin
    case (cnt_reg)
      3'd0:    inc = 4'd0;
      3'd1:    inc = 4'd1;
      3'd2:    inc = 4'd3;
      3'd3:    inc = 4'd5;
      default: inc = 4'd8;
    endcase
  end
  assign score_sum = {1'b0, score_reg} + {13'd0, inc};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      for (int i = 0; i < ROWS; i++) begin
        occ_reg[i] <= '0;
        for (int j = 0; j < COLS; j++) col_reg[i][j] <= '0;
      end
      lx_reg         <= '0;
      ly_reg         <= '0;
      lc_reg         <= '0;
      r_reg          <= '0;
      cnt_reg        <= '0;
      score_reg      <= '0;
      lines_last_reg <= '0;
      clear_done_reg <= 1'b0;
      game_over_reg  <= 1'b0;
    end else begin
      clear_done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (lock_valid && lock_ready) begin
            lx_reg    <= lock_x;
            ly_reg    <= lock_y;
            lc_reg    <= lock_color;
            state_reg <= S_WRITE;
          end
        end
        S_WRITE: begin
          for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
              occ_reg[wr_y[k]][wr_x[k]] <= 1'b1;
              col_reg[wr_y[k]][wr_x[k]] <= lc_reg;
            end
          end
          r_reg     <= YW'(ROWS - 1);
          cnt_reg   <= '0;
          state_reg <= S_SCAN;
        end
        S_SCAN: begin
          if (row_full)           state_reg <= S_SHIFT;
          else if (r_reg != '0)   r_reg     <= r_m1;
          else                    state_reg <= S_DONE;
        end
        S_SHIFT: begin
          for (int i = 1; i < ROWS; i++) begin
            if (i <= int'(r_reg)) begin
              occ_reg[i] <= occ_reg[i-1];
              col_reg[i] <= col_reg[i-1];
            end
          end
          occ_reg[0] <= '0;
          for (int j = 0; j < COLS; j++) col_reg[0][j] <= '0;
          if (cnt_reg != 3'd7) cnt_reg <= cnt_reg + 3'd1;
          // Row r-1 is what lands in row r, so its fullness is the rescan result:
          // stay here for back-to-back clears, otherwise row r is known clean.
          if (r_reg == '0)       state_reg <= S_DONE;
          else if (!above_full) begin
            r_reg     <= r_m1;
            state_reg <= S_SCAN;
          end
        end
        S_DONE: begin
          clear_done_reg <= 1'b1;
          lines_last_reg <= cnt_reg;
          score_reg      <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
          game_over_reg  <= game_over_reg | spawn_occ;
          state_reg      <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign lock_ready = (state_reg == S_IDLE) && !game_over_reg;
  assign clear_done = clear_done_reg;
  assign lines_last = lines_last_reg;
  assign score      = score_reg;
  assign game_over  = game_over_reg;

endmodule

// File: tb/tb_playfield_lock_clear.sv
// Directed bench: a 4x8 field for lock/clear/score sequences and a 5x10 field
// where out-of-range coordinates are representable.
module tb_playfield_lock_clear;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 4 x 8 instance
  logic        lock_valid = 1'b0, lock_ready;
  logic [7:0]  lock_x = '0, q_x = '0;
  logic [11:0] lock_y = '0, q_y = '0;
  logic [2:0]  lock_color = '0, rd_color, lines_last;
  logic [1:0]  rd_x = '0;
  logic [2:0]  rd_y = '0;
  logic        q_hit, rd_occ, clear_done, game_over;
  logic [15:0] score;

  playfield_lock_clear #(.COLS(4), .ROWS(8), .CW(3), .SPAWN_ROWS(2)) u_dut (
    .clk(clk), .reset(reset), .lock_valid(lock_valid), .lock_ready(lock_ready),
    .lock_x(lock_x), .lock_y(lock_y), .lock_color(lock_color),
    .q_x(q_x), .q_y(q_y), .q_hit(q_hit), .rd_x(rd_x), .rd_y(rd_y),
    .rd_occ(rd_occ), .rd_color(rd_color), .clear_done(clear_done),
    .lines_last(lines_last), .score(score), .game_over(game_over));

  // 5 x 10 instance
  logic        o_valid = 1'b0, o_ready;
  logic [11:0] o_lock_x = '0, o_q_x = '0;
  logic [15:0] o_lock_y = '0, o_q_y = '0;
  logic [2:0]  o_color = '0, o_rd_color, o_lines;
  logic [2:0]  o_rd_x = '0;
  logic [3:0]  o_rd_y = '0;
  logic        o_q_hit, o_rd_occ, o_done, o_go;
  logic [15:0] o_score;

  playfield_lock_clear #(.COLS(5), .ROWS(10), .CW(3), .SPAWN_ROWS(2)) u_odd (
    .clk(clk), .reset(reset), .lock_valid(o_valid), .lock_ready(o_ready),
    .lock_x(o_lock_x), .lock_y(o_lock_y), .lock_color(o_color),
    .q_x(o_q_x), .q_y(o_q_y), .q_hit(o_q_hit), .rd_x(o_rd_x), .rd_y(o_rd_y),
    .rd_occ(o_rd_occ), .rd_color(o_rd_color), .clear_done(o_done),
    .lines_last(o_lines), .score(o_score), .game_over(o_go));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] px(input int a, input int b, input int c, input int d);
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction

  function automatic logic [11:0] py(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic probe(input int x, input int y, output logic o, output logic [2:0] c);
    rd_x = 2'(x);
    rd_y = 3'(y);
    #1;
    o = rd_occ;
    c = rd_color;
  endtask

  task automatic count_cells(output int n);
    logic o;
    logic [2:0] c;
    n = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 4; x++) begin
        probe(x, y, o, c);
        if (o) n++;
      end
  endtask

  // Offers one piece and follows the sequence; lat counts edges from the
  // handshake to the first edge at which lock_ready is sampled high again.
  task automatic do_lock(input logic [7:0] xs, input logic [11:0] ys, input logic [2:0] c,
                         output int lat, output int lines, output int dones, output logic tail);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!lock_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    lock_x = xs; lock_y = ys; lock_color = c; lock_valid = 1'b1;
    @(posedge clk);
    #1;
    lock_valid = 1'b0; lock_x = ~xs; lock_y = ~ys; lock_color = ~c;
    lat = 0; lines = -1; dones = 0;
    do begin
      @(negedge clk);
      lat++;
      if (clear_done) begin
        dones++;
        lines = int'(lines_last);
      end
    end while (!lock_ready && lat < 60);
    @(negedge clk);
    tail = clear_done;
  endtask

  typedef struct {
    logic [7:0]  xs;
    logic [11:0] ys;
    logic [2:0]  c;
    int          lat;
    int          lines;
    int          score;
    int          prx;
    int          pry;
    logic        pocc;
    logic [2:0]  pcol;
    int          ncells;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lat, lines, dones, n, seen;
    logic tail, o;
    logic [2:0] c;

    vecs[0] = '{px(0,0,0,0), py(4,5,6,7), 3'd1, 11, 0, 0,  0, 5, 1'b1, 3'd1, 4};
    vecs[1] = '{px(1,1,1,1), py(4,5,6,7), 3'd2, 11, 0, 0,  1, 7, 1'b1, 3'd2, 8};
    vecs[2] = '{px(2,2,2,2), py(4,5,6,7), 3'd3, 11, 0, 0,  2, 4, 1'b1, 3'd3, 12};
    vecs[3] = '{px(3,3,3,3), py(4,5,6,7), 3'd4, 15, 4, 8,  3, 7, 1'b0, 3'd0, 0};
    vecs[4] = '{px(0,1,2,3), py(7,7,7,7), 3'd5, 12, 1, 9,  0, 7, 1'b0, 3'd0, 0};
    vecs[5] = '{px(0,1,2,0), py(7,7,7,6), 3'd3, 11, 0, 9,  0, 6, 1'b1, 3'd3, 4};
    vecs[6] = '{px(1,2,1,2), py(6,6,5,5), 3'd4, 11, 0, 9,  2, 5, 1'b1, 3'd4, 8};
    vecs[7] = '{px(3,3,3,3), py(4,5,6,7), 3'd5, 13, 2, 12, 3, 6, 1'b1, 3'd5, 4};
    vecs[8] = '{px(0,0,0,1), py(7,5,4,4), 3'd6, 12, 1, 13, 0, 6, 1'b1, 3'd6, 4};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", lock_ready, 1);
    chk("rst_score", score, 0);
    chk("rst_lines", lines_last, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_gameover", game_over, 0);
    q_x = px(0,1,2,3); q_y = py(0,7,3,5); #1;
    chk("rst_qhit", q_hit, 0);
    count_cells(n);
    chk("rst_cells", n, 0);

    // Out-of-range coordinates on the 5x10 field
    o_q_x = {3'd0, 3'd0, 3'd0, 3'd5}; o_q_y = '0; #1;
    chk("odd_q_x5", o_q_hit, 1);
    o_q_x = '0; o_q_y = {4'd0, 4'd0, 4'd10, 4'd0}; #1;
    chk("odd_q_y10", o_q_hit, 1);
    o_q_x = {3'd0, 3'd4, 3'd0, 3'd4}; o_q_y = {4'd9, 4'd0, 4'd0, 4'd9}; #1;
    chk("odd_q_edge_empty", o_q_hit, 0);
    @(negedge clk);
    o_lock_x = {3'd4, 3'd1, 3'd0, 3'd5}; o_lock_y = {4'd9, 4'd9, 4'd9, 4'd9};
    o_color = 3'd7; o_valid = 1'b1;
    @(posedge clk);
    #1 o_valid = 1'b0;
    lat = 0; seen = 0;
    while (seen == 0 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (o_done) seen = 1;
    end
    chk("odd_latency", lat, 13);
    chk("odd_lines", o_lines, 0);
    o_rd_x = 3'd4; o_rd_y = 4'd9; #1;
    chk("odd_rd_occ", o_rd_occ, 1);
    chk("odd_rd_color", o_rd_color, 7);
    o_rd_x = 3'd3; #1;
    chk("odd_rd_gap", o_rd_occ, 0);
    o_rd_x = 3'd5; #1;
    chk("odd_rd_oob", o_rd_occ, 0);

    for (int i = 0; i < 9; i++) begin
      do_lock(vecs[i].xs, vecs[i].ys, vecs[i].c, lat, lines, dones, tail);
      $display("vec %0d lat=%0d lines=%0d score=%0d", i, lat, lines, score);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_dones", i), dones, 1);
      chk($sformatf("v%0d_lines", i), lines, vecs[i].lines);
      chk($sformatf("v%0d_done_tail", i), tail, 0);
      chk($sformatf("v%0d_score", i), score, vecs[i].score);
      chk($sformatf("v%0d_gameover", i), game_over, 0);
      probe(vecs[i].prx, vecs[i].pry, o, c);
      chk($sformatf("v%0d_probe_occ", i), o, vecs[i].pocc);
      chk($sformatf("v%0d_probe_color", i), c, vecs[i].pcol);
      count_cells(n);
      chk($sformatf("v%0d_cells", i), n, vecs[i].ncells);
    end

    // Field now: row7 col3 (c5), row6 col0 (c6), row5 cols0,1 (c6)
    probe(3, 7, o, c);
    chk("post_rd37_color", c, 5);
    probe(1, 5, o, c);
    chk("post_rd15_occ", o, 1);
    probe(1, 4, o, c);
    chk("post_rd14_occ", o, 0);
    q_x = px(0,1,2,3); q_y = py(0,0,0,7); #1;
    chk("post_qhit_one", q_hit, 1);
    q_x = px(2,2,1,0); q_y = py(7,6,6,7); #1;
    chk("post_qhit_none", q_hit, 0);

    // Reset while the completed row is being shifted
    @(negedge clk);
    lock_x = px(0,1,2,3); lock_y = py(7,7,7,7); lock_color = 3'd2; lock_valid = 1'b1;
    @(posedge clk);
    #1 lock_valid = 1'b0;
    @(negedge clk);
    probe(0, 7, o, c);
    chk("midseq_write_pending", o, 0);
    @(negedge clk);
    probe(0, 7, o, c);
    chk("midseq_scan_view", o, 1);
    chk("midseq_busy", lock_ready, 0);
    @(negedge clk);
    q_x = px(0,0,0,0); q_y = py(7,7,7,7); #1;
    chk("midseq_shift_qhit", q_hit, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", lock_ready, 1);
    chk("midrst_score", score, 0);
    chk("midrst_done", clear_done, 0);
    chk("midrst_lines", lines_last, 0);
    count_cells(n);
    chk("midrst_cells", n, 0);
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (clear_done) seen++;
    end
    chk("midrst_no_pulse", seen, 0);

    // Piece reaching row 1 ends the game
    do_lock(px(2,2,2,2), py(1,2,3,4), 3'd3, lat, lines, dones, tail);
    $display("gameover lock lat=%0d lines=%0d score=%0d", lat, lines, score);
    chk("go_dones", dones, 1);
    chk("go_lines", lines, 0);
    chk("go_flag", game_over, 1);
    chk("go_ready", lock_ready, 0);
    lock_x = px(0,1,2,3); lock_y = py(7,7,7,7); lock_color = 3'd1; lock_valid = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (clear_done || lock_ready) seen++;
    end
    lock_valid = 1'b0;
    chk("go_ignored", seen, 0);
    probe(0, 7, o, c);
    chk("go_no_write", o, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("go_rst_flag", game_over, 0);
    chk("go_rst_ready", lock_ready, 1);
    probe(2, 1, o, c);
    chk("go_rst_cell", o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
